// File: rtl/fec_chain_sequencer.sv
// Control sequencer for the FEC loopback chain: ADC ingest handshake, one-word
// chain walk through encoder/modulator/demodulator/decoder, paced output reads.
module fec_chain_sequencer #(
   parameter int ENC_LAT    = 2,
   parameter int MOD_LAT    = 2,
   parameter int DEMOD_LAT  = 2,
   parameter int DEC_LAT    = 2,
   parameter int OUT_GAP    = 4,
   parameter int RD_TIMEOUT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req,
   output logic ack,
   input  logic in_full,
   input  logic in_empty,
   input  logic in_rd_valid,
   output logic in_wr_en,
   output logic in_rd_en,
   input  logic out_full,
   input  logic out_empty,
   input  logic out_rd_valid,
   output logic out_wr_en,
   output logic out_rd_en,
   output logic en_encoder,
   output logic en_modulator,
   output logic en_demodulator,
   output logic en_decoder,
   output logic out_valid,
   output logic busy,
   output logic err_timeout
);

   typedef enum logic [2:0] {
      IDLE, FETCH, WAIT_RD, ENC, MOD, DEMOD, DEC, WRITE
   } state_t;

   localparam logic [3:0] ENC_LOAD   = 4'(ENC_LAT - 1);
   localparam logic [3:0] MOD_LOAD   = 4'(MOD_LAT - 1);
   localparam logic [3:0] DEMOD_LOAD = 4'(DEMOD_LAT - 1);
   localparam logic [3:0] DEC_LOAD   = 4'(DEC_LAT - 1);
   localparam logic [3:0] GAP_LOAD   = 4'(OUT_GAP - 1);
   localparam logic [3:0] RD_LOAD    = 4'(RD_TIMEOUT - 1);

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [3:0] gap_cnt;
   logic       set_err;
   logic       accept;
   logic       rd_fire;

   // The !ack term limits ingest to one word every two cycles.
   assign accept    = req & en & ~in_full & ~ack;
   assign rd_fire   = en & ~out_empty & (gap_cnt == 4'd0) & ~out_rd_en;
   assign out_valid = out_rd_valid;

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      set_err = 1'b0;
      case (state)
         IDLE:
            if (en && !in_empty && !out_full) state_n = FETCH;
         FETCH: begin
            state_n = WAIT_RD;
            cnt_n   = RD_LOAD;
         end
         WAIT_RD:
            if (in_rd_valid) begin
               state_n = ENC;
               cnt_n   = ENC_LOAD;
            end else if (cnt == 4'd0) begin
               state_n = IDLE;
               set_err = 1'b1;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         ENC:
            if (cnt == 4'd0) begin
               state_n = MOD;
               cnt_n   = MOD_LOAD;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         MOD:
            if (cnt == 4'd0) begin
               state_n = DEMOD;
               cnt_n   = DEMOD_LOAD;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         DEMOD:
            if (cnt == 4'd0) begin
               state_n = DEC;
               cnt_n   = DEC_LOAD;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         DEC:
            if (cnt == 4'd0) state_n = WRITE;
            else cnt_n = cnt - 4'd1;
         WRITE:
            state_n = IDLE;
         default:
            state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Strobes are decoded from the next state so they are flop outputs that
   // line up with the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_rd_en       <= 1'b0;
         en_encoder     <= 1'b0;
         en_modulator   <= 1'b0;
         en_demodulator <= 1'b0;
         en_decoder     <= 1'b0;
         out_wr_en      <= 1'b0;
         busy           <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         in_rd_en       <= (state_n == FETCH);
         en_encoder     <= (state_n == ENC);
         en_modulator   <= (state_n == MOD);
         en_demodulator <= (state_n == DEMOD);
         en_decoder     <= (state_n == DEC);
         out_wr_en      <= (state_n == WRITE);
         busy           <= (state_n != IDLE);
         if (set_err) err_timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack      <= 1'b0;
         in_wr_en <= 1'b0;
      end else begin
         ack      <= accept;
         in_wr_en <= accept;
      end
   end

   // Gap counter loads on the same edge the read strobe rises, giving a read
   // spacing of exactly OUT_GAP cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_rd_en <= 1'b0;
         gap_cnt   <= 4'd0;
      end else begin
         out_rd_en <= rd_fire;
         if (rd_fire) gap_cnt <= GAP_LOAD;
         else if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
      end
   end

endmodule

// File: tb/tb_fec_chain_sequencer.sv
// Directed self-checking bench for fec_chain_sequencer with default parameters.
module tb_fec_chain_sequencer;

   logic clk, rst_n, en, req, ack;
   logic in_full, in_empty, in_rd_valid, in_wr_en, in_rd_en;
   logic out_full, out_empty, out_rd_valid, out_wr_en, out_rd_en;
   logic en_encoder, en_modulator, en_demodulator, en_decoder;
   logic out_valid, busy, err_timeout;

   int assertions = 0;
   int failures   = 0;

   fec_chain_sequencer dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ack(ack),
      .in_full(in_full), .in_empty(in_empty), .in_rd_valid(in_rd_valid),
      .in_wr_en(in_wr_en), .in_rd_en(in_rd_en),
      .out_full(out_full), .out_empty(out_empty), .out_rd_valid(out_rd_valid),
      .out_wr_en(out_wr_en), .out_rd_en(out_rd_en),
      .en_encoder(en_encoder), .en_modulator(en_modulator),
      .en_demodulator(en_demodulator), .en_decoder(en_decoder),
      .out_valid(out_valid), .busy(busy), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertions++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] chain_vec();
      return {in_rd_en, en_encoder, en_modulator, en_demodulator,
              en_decoder, out_wr_en, busy, err_timeout};
   endfunction

   function automatic logic [11:0] all_outs();
      return {ack, in_wr_en, in_rd_en, out_wr_en, out_rd_en, en_encoder,
              en_modulator, en_demodulator, en_decoder, out_valid, busy, err_timeout};
   endfunction

   // Expected {in_rd_en,enc,mod,demod,dec,out_wr_en,busy,err} per cycle after
   // the first fetch: full word, one idle cycle, then a fetch that times out.
   function automatic logic [7:0] chain_exp(input int c);
      case (c)
         0:       return 8'b1000_0010;
         1:       return 8'b0000_0010;
         2, 3:    return 8'b0100_0010;
         4, 5:    return 8'b0010_0010;
         6, 7:    return 8'b0001_0010;
         8, 9:    return 8'b0000_1010;
         10:      return 8'b0000_0110;
         11:      return 8'b0000_0000;
         12:      return 8'b1000_0010;
         13, 14,
         15, 16:  return 8'b0000_0010;
         default: return 8'b0000_0001;
      endcase
   endfunction

   initial begin
      logic [15:0] ack_pat;
      logic        prev_ack;
      int          ack_count;

      rst_n = 1'b1; en = 1'b0; req = 1'b0;
      in_full = 1'b0; in_empty = 1'b1; in_rd_valid = 1'b0;
      out_full = 1'b0; out_empty = 1'b1; out_rd_valid = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check("reset_outputs", 32'(all_outs()), 32'h0);
      step();
      rst_n = 1'b1;
      en    = 1'b1;

      // Single ingest.
      req = 1'b1;
      step();
      check("single_ack", 32'({ack, in_wr_en}), 32'b11);
      req = 1'b0;
      step();
      check("single_ack_drop", 32'({ack, in_wr_en}), 32'b00);

      // One word through the chain, then a fetch that never gets read data.
      in_empty = 1'b0;
      for (int c = 0; c <= 17; c++) begin
         step();
         check($sformatf("chain_c%0d", c), 32'(chain_vec()), 32'(chain_exp(c)));
         in_rd_valid = (c == 1);
         if (c == 12) in_empty = 1'b1;
      end
      repeat (5) step();
      check("err_sticky", 32'({err_timeout, busy}), 32'b10);

      // req held for ten cycles: alternate acks, five total.
      req = 1'b1;
      ack_count = 0;
      prev_ack  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("burst_ack_%0d", i), 32'(ack), 32'((i % 2) == 0));
         check($sformatf("burst_consec_%0d", i), 32'(ack & prev_ack), 32'h0);
         if (ack) ack_count++;
         prev_ack = ack;
      end
      check("burst_ack_count", 32'(ack_count), 32'd5);
      req = 1'b0;
      step();
      step();

      // Burst with in_full raised mid-way.
      ack_pat = 16'h5505;
      req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         check($sformatf("full_ack_%0d", i), 32'({ack, in_wr_en}), {30'd0, ack_pat[i], ack_pat[i]});
         in_full = (i >= 2 && i <= 6);
      end
      req = 1'b0;
      in_full = 1'b0;
      step();

      // Output pacing with OUT_GAP=4 and out_valid pass-through.
      out_empty = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         check($sformatf("pace_%0d", i), 32'(out_rd_en), 32'((i % 4) == 0));
         out_rd_valid = i[0];
         #1;
         check($sformatf("out_valid_%0d", i), 32'(out_valid), 32'(i[0]));
      end
      en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("pace_en_low_%0d", i), 32'(out_rd_en), 32'h0);
      end
      out_empty = 1'b1;
      out_rd_valid = 1'b0;
      en = 1'b1;
      step();

      // en dropped during MOD: word still completes, no new fetch or ack.
      in_empty = 1'b0;
      for (int c = 0; c <= 15; c++) begin
         step();
         if (c == 4)  check("mod_active", 32'(en_modulator), 32'h1);
         if (c == 10) check("en_low_write", 32'({out_wr_en, busy}), 32'b11);
         if (c >= 11) check($sformatf("en_low_idle_%0d", c),
                            32'({in_rd_en, busy, ack}), 32'h0);
         in_rd_valid = (c == 1);
         if (c == 4) begin
            en  = 1'b0;
            req = 1'b1;
         end
      end
      en  = 1'b1;
      req = 1'b0;

      // Reset asserted during DEMOD.
      for (int c = 0; c <= 6; c++) begin
         step();
         in_rd_valid = (c == 1);
      end
      check("demod_active", 32'(en_demodulator), 32'h1);
      rst_n = 1'b0;
      #2;
      check("async_reset_outputs", 32'(all_outs()), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      check("restart_fetch", 32'(chain_vec()), 32'b1000_0010);
      in_empty = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/fec_chain_sequencer.md
# fec_chain_sequencer

Control-only sequencer for the FEC loopback chain (input buffer -> encoder -> modulator -> demodulator -> decoder -> output buffer). It accepts ADC words over a req/ack handshake, moves one word at a time through the four processing stages by pulsing their enables for fixed per-stage latencies, and paces the output buffer toward the DAC. It carries no data; the data path is wired directly between buffers and stages.

## Interface
- ENC_LAT, 2: cycles en_encoder is held per word (1..16)
- MOD_LAT, 2: cycles en_modulator is held per word (1..16)
- DEMOD_LAT, 2: cycles en_demodulator is held per word (1..16)
- DEC_LAT, 2: cycles en_decoder is held per word (1..16)
- OUT_GAP, 4: minimum cycles between output-buffer reads (1..16)
- RD_TIMEOUT, 4: cycles to wait for in_rd_valid after a fetch (1..15)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  1  global enable
- req  in  1  word-available request from ADC side (level)
- ack  out  1  one-cycle pulse: word accepted
- in_full  in  1  input buffer full
- in_empty  in  1  input buffer empty
- in_rd_valid  in  1  input buffer read data valid
- in_wr_en  out  1  input buffer write strobe
- in_rd_en  out  1  input buffer read strobe
- out_full  in  1  output buffer full
- out_empty  in  1  output buffer empty
- out_rd_valid  in  1  output buffer read data valid
- out_wr_en  out  1  output buffer write strobe
- out_rd_en  out  1  output buffer read strobe
- en_encoder, en_modulator, en_demodulator, en_decoder  out  1 each  stage enables
- out_valid  out  1  DAC data valid
- busy  out  1  chain FSM not in IDLE
- err_timeout  out  1  sticky: fetch timed out

## Operation
- All outputs registered except out_valid = out_rd_valid (pass-through). Reset: every output 0, chain FSM IDLE, all counters 0, err_timeout cleared.
- Ingest (independent of chain FSM): accept when req & en & !in_full & !ack. On accept, next cycle ack=1 and in_wr_en=1 for exactly one cycle. Max rate one word per 2 cycles. req high while in_full: no ack, no write, wait.
- Chain FSM states: IDLE, FETCH, WAIT_RD, ENC, MOD, DEMOD, DEC, WRITE.
  - IDLE -> FETCH when en & !in_empty & !out_full.
  - FETCH: in_rd_en=1 for one cycle -> WAIT_RD.
  - WAIT_RD: on in_rd_valid -> ENC; if RD_TIMEOUT cycles pass without it, set err_timeout -> IDLE.
  - ENC/MOD/DEMOD/DEC: corresponding enable high for exactly *_LAT cycles (4-bit down-counter), only one stage enable high at a time, then next state; DEC -> WRITE.
  - WRITE: out_wr_en=1 for one cycle -> IDLE. out_full is not rechecked (guaranteed by IDLE check; chain holds one word max).
- en low: no new accepts, no IDLE->FETCH, no output reads; a word already past IDLE completes through WRITE.
- Output pacing: gap counter loads OUT_GAP-1 on each out_rd_en and counts to 0; out_rd_en=1 for one cycle when en & !out_empty & gap counter 0 & !out_rd_en.
- Same-cycle out_wr_en and out_rd_en allowed (buffer handles it).
- Reset mid-operation: in-flight word dropped, all strobes and enables deassert asynchronously.
- err_timeout cleared only by reset.

## Timing
- Ingest: req sampled at edge N -> ack, in_wr_en high in cycle N+1.
- Chain latency from FETCH entry with in_rd_valid one cycle after in_rd_en: 1 (FETCH) + 1 (WAIT_RD) + ENC_LAT + MOD_LAT + DEMOD_LAT + DEC_LAT + 1 (WRITE) cycles; defaults = 11, then 1 cycle IDLE before next FETCH (throughput one word per 12 cycles).
- busy high from FETCH through WRITE inclusive.
- out_rd_en spacing exactly OUT_GAP cycles while output buffer non-empty and en high; OUT_GAP=1 reads every other cycle (no back-to-back due to !out_rd_en term).

## Test plan
- Reset then single req (in_full=0): ack and in_wr_en one-cycle pulse at cycle after req; with in_empty then 0 and in_rd_valid 1 cycle after in_rd_en, defaults -> en_encoder 2 cycles, en_modulator 2, en_demodulator 2, en_decoder 2, out_wr_en 11 cycles after FETCH entry.
- req held high 10 cycles, in_full=0: exactly 5 ack pulses, never consecutive; raise in_full mid-burst -> acks stop until in_full falls.
- in_rd_valid never returned: err_timeout sets 4 cycles after WAIT_RD entry, FSM returns to IDLE, no stage enable fired; stays set until rst_n low.
- out_empty=0 continuously, OUT_GAP=4: out_rd_en pulses every 4 cycles; out_valid mirrors out_rd_valid; en drop stops pulses next cycle.
- en dropped during MOD: word completes to out_wr_en, then FSM stays IDLE with in_empty=0; no ack while en low.
- rst_n asserted during DEMOD: all outputs 0 immediately (no clock), busy 0; after release FSM restarts from IDLE.
